// File: rtl/keyboard_matrix_resp.sv
// keyboard_matrix_resp: answers the POKEY keyboard scanner on behalf of a host.
// Host key events {shift,code} are queued, then each key is "pressed" for
// HOLD_SCANS scanner revolutions and released for REL_SCANS revolutions.
// Optional feature macro: KBD_AUTOREPEAT_EN (key_hold keeps a key pressed).
module keyboard_matrix_resp #(
  parameter int HOLD_SCANS = 4,
  parameter int REL_SCANS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       o2,
  input  logic       rst_L,
  input  logic [3:0] key_scan_L,
  input  logic [3:0] key_code,
  input  logic       key_shift,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       key_hold,
  output logic       kr1_L,
  output logic       kr2_L,
  output logic       busy
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int MAXS = (HOLD_SCANS > REL_SCANS) ? HOLD_SCANS : REL_SCANS;
  localparam int SW   = $clog2(MAXS + 1);

  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);
  localparam logic [SW-1:0]   HOLD_LAST = SW'(HOLD_SCANS - 1);
  localparam logic [SW-1:0]   REL_LAST  = SW'(REL_SCANS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [3:0]      cur_code_q, cur_code_d;
  logic            cur_shift_q, cur_shift_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [4:0]      mem_q [FIFO_DEPTH];
  logic [4:0]      mem_d [FIFO_DEPTH];

  logic push_s;
  logic pop_s;
  logic boundary_s;
  logic repeat_s;
  logic press_match_s;

`ifdef KBD_AUTOREPEAT_EN
  assign repeat_s = key_hold;
`else
  logic unused_key_hold;
  assign unused_key_hold = key_hold;
  assign repeat_s        = 1'b0;
`endif

  // Acceptance depends only on registered occupancy, so a same-cycle pop never opens a full queue.
  assign key_ready  = (count_q < DEPTH_C);
  assign push_s     = key_valid && key_ready;
  assign pop_s      = (state_q == S_IDLE) && (count_q != '0);
  assign boundary_s = (key_scan_L == 4'hF);

  // Queue storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {key_shift, key_code};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Press/release sequencing, counted in scanner revolutions.
  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    cur_code_d  = cur_code_q;
    cur_shift_d = cur_shift_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          {cur_shift_d, cur_code_d} = mem_q[rd_ptr_q];
          scan_cnt_d = '0;
          state_d    = S_PRESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESS: begin
        if (boundary_s) begin
          if (scan_cnt_q >= HOLD_LAST) begin
            scan_cnt_d = '0;
            state_d    = repeat_s ? S_PRESS : S_RELEASE;
          end else begin
            scan_cnt_d = scan_cnt_q + SW'(1);
          end
        end else begin
          scan_cnt_d = scan_cnt_q;
        end
      end
      S_RELEASE: begin
        if (boundary_s) begin
          if (scan_cnt_q >= REL_LAST) begin
            scan_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            scan_cnt_d = scan_cnt_q + SW'(1);
          end
        end else begin
          scan_cnt_d = scan_cnt_q;
        end
      end
      default: begin
        state_d    = S_IDLE;
        scan_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset empties the queue and releases any pressed key.
  always_ff @(posedge o2 or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= S_IDLE;
      scan_cnt_q  <= '0;
      cur_code_q  <= 4'd0;
      cur_shift_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_q       <= '{default: 5'd0};
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      cur_code_q  <= cur_code_d;
      cur_shift_q <= cur_shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  // Returns are combinational so the scanner sees them in the same cycle it drives key_scan_L.
  assign press_match_s = (state_q == S_PRESS) && ((~key_scan_L) == cur_code_q);
  assign kr1_L         = ~press_match_s;
  assign kr2_L         = ~(press_match_s && cur_shift_q);
  assign busy          = (state_q != S_IDLE) || (count_q != '0);

endmodule
